stack_program_runner: RTL and testbench
=======================================

# stack_program_runner

Run controller for `stackCPU`. It owns a small program memory loaded over a ready/valid stream, holds the CPU in reset while idle, and releases it to execute on `start`. It feeds instructions indexed by the CPU's `pc`, tracks each retired result, and ends the run on halt, error, end-of-program or watchdog timeout. It reports a sticky completion record until the host acknowledges it.

## Interface
Parameters:
- DATA_WIDTH, 32, CPU result width
- INSTR_WIDTH, 10, instruction width
- PC_WIDTH, 10, CPU program-counter width
- PROG_DEPTH, 64, program memory entries (power of two, ≤ 2**PC_WIDTH)
- TIMEOUT, 1024, maximum RUN cycles before forced stop (≥ 2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  instruction beat valid
- load_ready  out  1  runner accepts a beat
- load_instr  in  INSTR_WIDTH  instruction to store
- load_last  in  1  marks the final beat of a program
- start  in  1  begin execution (sampled in IDLE only)
- busy  out  1  state is LOAD or RUN
- done  out  1  completion record valid (state DONE)
- done_ack  in  1  clears the record, returns to IDLE
- done_result  out  DATA_WIDTH  last retired CPU result (signed)
- done_error  out  1  run ended on `cpu_error`
- done_timeout  out  1  run ended on the watchdog
- done_cycles  out  16  RUN cycles consumed (saturates at 16'hFFFF)
- cpu_reset  out  1  drives the CPU reset
- cpu_instruction  out  INSTR_WIDTH  to the CPU instruction input
- cpu_pc  in  PC_WIDTH  from the CPU
- cpu_result  in  DATA_WIDTH  from the CPU
- cpu_error, cpu_halt  in  1 each  from the CPU

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Reset values: state IDLE, prog_len 0, write pointer 0, all `done_*` 0, busy 0, done 0, load_ready 0, cpu_reset 1, cpu_instruction 0. Memory contents are not cleared.
- IDLE:
  - load_ready=1.
  - An accepted beat writes mem[0] and sets the write pointer to 1. Without load_last it goes to LOAD; with load_last it sets prog_len=1 and stays in IDLE.
  - start with prog_len≠0 goes to RUN. start with prog_len=0 is ignored.
  - A beat accepted together with start has priority, and start is dropped.
- LOAD:
  - load_ready=1 while the write pointer is below PROG_DEPTH.
  - Each accepted beat writes mem[ptr] and increments ptr.
  - On a beat with load_last, prog_len is set to the count including that beat and the state goes to IDLE.
  - With the pointer at PROG_DEPTH, load_ready=0. A following load_valid+load_last with no data sets prog_len=PROG_DEPTH and goes to IDLE.
  - start is ignored.
- RUN:
  - cpu_reset=0; in every other state cpu_reset=1.
  - cpu_instruction = mem[cpu_pc] when cpu_pc < prog_len, else 0. The read is combinational.
  - pc_q registers cpu_pc and res_q registers cpu_result each cycle; both are cleared on RUN entry.
  - Retire is defined as cpu_pc ≠ pc_q; on retire, done_result ← res_q.
  - The cycle counter increments every RUN cycle.
- RUN exit conditions, evaluated each cycle, highest priority first. Each goes to DONE.
  1. cpu_error: sets done_error=1.
  2. cpu_halt.
  3. cpu_pc ≥ prog_len (end of program).
  4. counter = TIMEOUT-1: sets done_timeout=1.
- DONE:
  - done=1; all `done_*` outputs are held stable.
  - done_ack goes to IDLE and clears done_error, done_timeout and done_cycles. done_result keeps its value.
  - prog_len is retained, so start from IDLE reruns the same program.
- load_valid outside IDLE/LOAD is ignored (load_ready=0).

## Timing
- start sampled at edge T: RUN from T+1, cpu_reset deasserted during cycle T+1, busy=1 from T+1.
- The exit condition is seen in cycle N; done=1 and busy=0 from N+1; cpu_reset is reasserted in N+1.
- done_cycles equals the number of RUN cycles, including cycle N.
- Retire detection trails the CPU pc update by 0 cycles. done_result updates the edge after retire.
- A load beat is written on the edge where load_valid && load_ready. The memory is readable the next cycle.
- done_ack is sampled only in DONE. Other cycles ignore it.
- reset in any state (including mid-RUN or mid-LOAD) returns to the reset values at the next edge. prog_len=0, so a reload is required.

## Test plan
- Load PUSH_IMMEDIATE 5, PUSH_IMMEDIATE 3, ADD (last on the third beat), then start → done with done_result=8, done_error=0, done_timeout=0; done_ack → IDLE, done_result still 8.
- Load PROG_DEPTH beats without last → load_ready=0 after beat PROG_DEPTH; then load_valid+load_last → prog_len=PROG_DEPTH, IDLE.
- Program PUSH_IMMEDIATE 7, PUSH_IMMEDIATE 0, DIV while the bench model raises cpu_error → done_error=1, done_timeout=0.
- TIMEOUT=8 with a 5-instruction program → done_timeout=1, done_cycles=8.
- Assert reset mid-RUN → next cycle IDLE, cpu_reset=1, busy=0; a following start without a reload is ignored.
- start with prog_len=0 → stays IDLE. start coincident with a load beat → the beat is written and start is dropped.

Source files
------------

// File: rtl/stack_program_runner.sv
// Run controller for stackCPU: loads a program over ready/valid, runs the CPU
// from that program memory, and holds a completion record until acknowledged.
module stack_program_runner #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 10,
  parameter int PC_WIDTH    = 10,
  parameter int PROG_DEPTH  = 64,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic                   load_last,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   done_ack,
  output logic [DATA_WIDTH-1:0]  done_result,
  output logic                   done_error,
  output logic                   done_timeout,
  output logic [15:0]            done_cycles,
  output logic                   cpu_reset,
  output logic [INSTR_WIDTH-1:0] cpu_instruction,
  input  logic [PC_WIDTH-1:0]    cpu_pc,
  input  logic [DATA_WIDTH-1:0]  cpu_result,
  input  logic                   cpu_error,
  input  logic                   cpu_halt
);

  localparam int AW   = $clog2(PROG_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMPW = (PC_WIDTH > LW) ? PC_WIDTH : LW;
  localparam int CW   = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           progLen_q, progLen_d;
  logic [LW-1:0]           wrPtr_q, wrPtr_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    error_q, error_d;
  logic                    timeout_q, timeout_d;
  logic [CW-1:0]           count_q, count_d;
  logic [INSTR_WIDTH-1:0]  mem [PROG_DEPTH];

  logic                    beatAccept;
  logic                    ptrFull;
  logic                    inProgram;
  logic [AW-1:0]           wrAddr;

  assign ptrFull    = (wrPtr_q == LW'(PROG_DEPTH));
  assign inProgram  = (CMPW'(cpu_pc) < CMPW'(progLen_q));
  assign wrAddr     = (state_q == LOAD) ? wrPtr_q[AW-1:0] : '0;
  assign load_ready = !reset && ((state_q == IDLE) || ((state_q == LOAD) && !ptrFull));
  assign beatAccept = load_valid && load_ready;

  // Program memory has no reset; it is only meaningful below prog_len.
  always_ff @(posedge clk) begin
    if (beatAccept) begin
      mem[wrAddr] <= load_instr;
    end
  end

  assign cpu_instruction = ((state_q == RUN) && inProgram) ? mem[cpu_pc[AW-1:0]] : '0;

  always_comb begin
    state_d   = state_q;
    progLen_d = progLen_q;
    wrPtr_d   = wrPtr_q;
    pc_d      = pc_q;
    res_d     = res_q;
    result_d  = result_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        // A load beat wins over start; start is simply dropped.
        if (beatAccept) begin
          wrPtr_d = LW'(1);
          if (load_last) begin
            progLen_d = LW'(1);
          end else begin
            state_d = LOAD;
          end
        end else if (start && (progLen_q != '0)) begin
          state_d = RUN;
          pc_d    = '0;
          res_d   = '0;
          count_d = '0;
        end
      end
      LOAD: begin
        if (beatAccept) begin
          wrPtr_d = wrPtr_q + LW'(1);
          if (load_last) begin
            progLen_d = wrPtr_q + LW'(1);
            state_d   = IDLE;
          end
        end else if (ptrFull && load_valid && load_last) begin
          progLen_d = LW'(PROG_DEPTH);
          state_d   = IDLE;
        end
      end
      RUN: begin
        pc_d    = cpu_pc;
        res_d   = cpu_result;
        count_d = count_q + CW'(1);
        // The result seen the cycle before a pc change belongs to the retiring instruction.
        if (cpu_pc != pc_q) begin
          result_d = res_q;
        end
        if (cpu_error) begin
          error_d = 1'b1;
          state_d = DONE;
        end else if (cpu_halt) begin
          state_d = DONE;
        end else if (!inProgram) begin
          state_d = DONE;
        end else if (count_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (done_ack) begin
          state_d   = IDLE;
          error_d   = 1'b0;
          timeout_d = 1'b0;
          count_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      progLen_q <= '0;
      wrPtr_q   <= '0;
      pc_q      <= '0;
      res_q     <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      progLen_q <= progLen_d;
      wrPtr_q   <= wrPtr_d;
      pc_q      <= pc_d;
      res_q     <= res_d;
      result_q  <= result_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign busy         = (state_q == LOAD) || (state_q == RUN);
  assign done         = (state_q == DONE);
  assign cpu_reset    = (state_q != RUN);
  assign done_result  = result_q;
  assign done_error   = error_q;
  assign done_timeout = timeout_q;
  assign done_cycles  = (count_q > CW'(16'hFFFF)) ? 16'hFFFF : count_q[15:0];

endmodule

// File: tb/tb_stack_program_runner.sv
// Bench for stack_program_runner with a small two-cycle-per-instruction stack CPU
// model; run results are queued as expectations at start and popped at done.
module tb_stack_program_runner;

  localparam int DW = 32;
  localparam int IW = 10;
  localparam int PW = 10;
  localparam int DEPTH = 64;
  localparam int TMO = 8;

  logic          clk;
  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic [IW-1:0] load_instr;
  logic          load_last;
  logic          start;
  logic          busy;
  logic          done;
  logic          done_ack;
  logic [DW-1:0] done_result;
  logic          done_error;
  logic          done_timeout;
  logic [15:0]   done_cycles;
  logic          cpu_reset;
  logic [IW-1:0] cpu_instruction;
  logic [PW-1:0] cpuPc;
  logic [DW-1:0] cpuRes;
  logic          cpuErr;
  logic          cpuHalt;

  stack_program_runner #(
    .DATA_WIDTH(DW), .INSTR_WIDTH(IW), .PC_WIDTH(PW), .PROG_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_instr(load_instr), .load_last(load_last),
    .start(start), .busy(busy), .done(done), .done_ack(done_ack),
    .done_result(done_result), .done_error(done_error), .done_timeout(done_timeout),
    .done_cycles(done_cycles), .cpu_reset(cpu_reset), .cpu_instruction(cpu_instruction),
    .cpu_pc(cpuPc), .cpu_result(cpuRes), .cpu_error(cpuErr), .cpu_halt(cpuHalt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU model: opcode in [9:8] (0 PUSH imm, 1 ADD, 2 DIV, 3 HALT); execute, then advance pc.
  int   stk [16];
  int   sp;
  logic phase;
  always @(posedge clk) begin
    if (cpu_reset) begin
      cpuPc <= '0; cpuRes <= '0; cpuErr <= 1'b0; cpuHalt <= 1'b0; phase <= 1'b0; sp <= 0;
    end else if (!cpuErr && !cpuHalt) begin
      if (!phase) begin
        phase <= 1'b1;
        case (cpu_instruction[9:8])
          2'd0: begin
            if (sp < 16) begin
              stk[sp] <= int'(cpu_instruction[7:0]);
              sp      <= sp + 1;
              cpuRes  <= {24'b0, cpu_instruction[7:0]};
            end else cpuErr <= 1'b1;
          end
          2'd1: begin
            if (sp >= 2) begin
              stk[sp-2] <= stk[sp-2] + stk[sp-1];
              sp        <= sp - 1;
              cpuRes    <= 32'(stk[sp-2] + stk[sp-1]);
            end else cpuErr <= 1'b1;
          end
          2'd2: begin
            if (sp >= 2 && stk[sp-1] != 0) begin
              stk[sp-2] <= stk[sp-2] / stk[sp-1];
              sp        <= sp - 1;
              cpuRes    <= 32'(stk[sp-2] / stk[sp-1]);
            end else cpuErr <= 1'b1;
          end
          default: cpuHalt <= 1'b1;
        endcase
      end else begin
        cpuPc <= cpuPc + 1'b1;
        phase <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [31:0] result;
    logic        err;
    logic        tmo;
    logic [15:0] cycles;
  } exp_t;

  exp_t          sbQ [$];
  logic [IW-1:0] progBuf [DEPTH];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [IW-1:0] mkInstr(input logic [1:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadBeats(input int n, input bit withLast);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_instr = progBuf[i];
      load_last  = withLast && (i == n - 1);
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Queue the expected completion record and pulse start.
  task automatic applyStimulus(input exp_t e);
    sbQ.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkValue("runBusy", {31'b0, busy}, 32'd1);
    checkValue("runCpuReset", {31'b0, cpu_reset}, 32'd0);
  endtask

  // Wait (bounded) for done, compare against the queue head, then acknowledge.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkValue({tag, "_doneSeen"}, {31'b0, done}, 32'd1);
    if (sbQ.size() == 0) begin
      checkValue({tag, "_queueEmpty"}, 32'd0, 32'd1);
      return;
    end
    e = sbQ.pop_front();
    checkValue({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkValue({tag, "_result"}, done_result, e.result);
    checkValue({tag, "_error"}, {31'b0, done_error}, {31'b0, e.err});
    checkValue({tag, "_timeout"}, {31'b0, done_timeout}, {31'b0, e.tmo});
    checkValue({tag, "_cycles"}, {16'b0, done_cycles}, {16'b0, e.cycles});
    done_ack = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
    checkValue({tag, "_ackDone"}, {31'b0, done}, 32'd0);
    checkValue({tag, "_ackResultKept"}, done_result, e.result);
    checkValue({tag, "_ackError"}, {31'b0, done_error}, 32'd0);
    checkValue({tag, "_ackCycles"}, {16'b0, done_cycles}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_instr = '0; load_last = 1'b0;
    start = 1'b0; done_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkValue("rstLoadReady", {31'b0, load_ready}, 32'd0);
    checkValue("rstBusy", {31'b0, busy}, 32'd0);
    checkValue("rstDone", {31'b0, done}, 32'd0);
    checkValue("rstCpuReset", {31'b0, cpu_reset}, 32'd1);
    checkValue("rstInstr", {22'b0, cpu_instruction}, 32'd0);
    checkValue("rstResult", done_result, 32'd0);
    checkValue("rstCycles", {16'b0, done_cycles}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkValue("idleLoadReady", {31'b0, load_ready}, 32'd1);

    $display("[TB] start with empty program");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkValue("emptyStartBusy", {31'b0, busy}, 32'd0);
    checkValue("emptyStartCpuReset", {31'b0, cpu_reset}, 32'd1);

    $display("[TB] 5 + 3");
    progBuf[0] = mkInstr(2'd0, 8'd5);
    progBuf[1] = mkInstr(2'd0, 8'd3);
    progBuf[2] = mkInstr(2'd1, 8'd0);
    loadBeats(3, 1'b1);
    checkValue("addLoadedIdle", {31'b0, busy}, 32'd0);
    applyStimulus('{result: 32'd8, err: 1'b0, tmo: 1'b0, cycles: 16'd7});
    checkOutput("add");
    applyStimulus('{result: 32'd8, err: 1'b0, tmo: 1'b0, cycles: 16'd7});
    checkOutput("addRerun");

    $display("[TB] divide by zero");
    progBuf[0] = mkInstr(2'd0, 8'd7);
    progBuf[1] = mkInstr(2'd0, 8'd0);
    progBuf[2] = mkInstr(2'd2, 8'd0);
    loadBeats(3, 1'b1);
    applyStimulus('{result: 32'd0, err: 1'b1, tmo: 1'b0, cycles: 16'd6});
    checkOutput("div0");

    $display("[TB] halt");
    progBuf[0] = mkInstr(2'd0, 8'd9);
    progBuf[1] = mkInstr(2'd3, 8'd0);
    loadBeats(2, 1'b1);
    applyStimulus('{result: 32'd9, err: 1'b0, tmo: 1'b0, cycles: 16'd4});
    checkOutput("halt");

    $display("[TB] watchdog");
    for (int i = 0; i < 5; i++) progBuf[i] = mkInstr(2'd0, 8'(i + 1));
    loadBeats(5, 1'b1);
    applyStimulus('{result: 32'd3, err: 1'b0, tmo: 1'b1, cycles: 16'd8});
    checkOutput("timeout");

    $display("[TB] full-depth load");
    for (int i = 0; i < DEPTH; i++) progBuf[i] = mkInstr(2'd0, 8'(i + 10));
    loadBeats(DEPTH, 1'b0);
    checkValue("fullLoadReady", {31'b0, load_ready}, 32'd0);
    checkValue("fullBusy", {31'b0, busy}, 32'd1);
    load_valid = 1'b1;
    load_last  = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    checkValue("fullLastIdle", {31'b0, busy}, 32'd0);
    checkValue("fullLastReady", {31'b0, load_ready}, 32'd1);
    applyStimulus('{result: 32'd12, err: 1'b0, tmo: 1'b1, cycles: 16'd8});
    checkOutput("full");

    $display("[TB] start coincident with a load beat");
    @(negedge clk);
    load_valid = 1'b1; load_last = 1'b1; load_instr = mkInstr(2'd0, 8'd42); start = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
    checkValue("coincBusy", {31'b0, busy}, 32'd0);
    checkValue("coincCpuReset", {31'b0, cpu_reset}, 32'd1);
    applyStimulus('{result: 32'd42, err: 1'b0, tmo: 1'b0, cycles: 16'd3});
    checkOutput("single");

    $display("[TB] reset mid-run");
    progBuf[0] = mkInstr(2'd0, 8'd5);
    progBuf[1] = mkInstr(2'd0, 8'd3);
    progBuf[2] = mkInstr(2'd1, 8'd0);
    loadBeats(3, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkValue("midRstBusy", {31'b0, busy}, 32'd0);
    checkValue("midRstCpuReset", {31'b0, cpu_reset}, 32'd1);
    checkValue("midRstDone", {31'b0, done}, 32'd0);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkValue("postRstStartBusy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkValue("postRstStartCpuReset", {31'b0, cpu_reset}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
